// File: rtl/light_pkg.sv
// Shared types and default timing constants for the light controller slice.
package light_pkg;

  typedef enum logic [1:0] {
    MANUAL_OFF,
    MANUAL_ON,
    AUTO_IDLE,
    AUTO_ON
  } light_state_t;

  localparam int unsigned DEF_AUTO_SHUTDOWN_T = 30000;
  localparam int unsigned DEF_WARN_T          = 5000;
  localparam int unsigned DEF_BLINK_P         = 500;

endpackage

// File: rtl/light_timer.sv
// Idle counter for AUTO_ON: saturating 16-bit count, timeout compare and,
// with LIGHT_CTRL_WARN_BLINK_EN defined, the pre-off warning blink generator.
module light_timer
  import light_pkg::*;
#(
  parameter int unsigned AUTO_SHUTDOWN_T = DEF_AUTO_SHUTDOWN_T
`ifdef LIGHT_CTRL_WARN_BLINK_EN
  ,
  parameter int unsigned WARN_T          = DEF_WARN_T,
  parameter int unsigned BLINK_P         = DEF_BLINK_P
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic en,       // staying in AUTO_ON across this edge
  input  logic clr,      // presence seen this cycle
  output logic expired
`ifdef LIGHT_CTRL_WARN_BLINK_EN
  ,
  output logic blank     // lamp dark during this warning cycle
`endif
);

  localparam logic [15:0] LAST = 16'(AUTO_SHUTDOWN_T - 1);

  logic [15:0] count;

  // Saturates at LAST; any state change or presence restarts from zero.
  always_ff @(posedge clk) begin
    if (rst || !en || clr) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == LAST);

`ifdef LIGHT_CTRL_WARN_BLINK_EN
  localparam logic [15:0] WARN_START = 16'(AUTO_SHUTDOWN_T - WARN_T);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_P - 1);

  logic [15:0] blink_cnt;
  logic        blink_lvl;
  logic        warn;

  assign warn = (count >= WARN_START);

  // Held cleared outside the window so the first warning cycle starts dark.
  always_ff @(posedge clk) begin
    if (rst || !en || clr || !warn) begin
      blink_cnt <= '0;
      blink_lvl <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_lvl <= ~blink_lvl;
    end else begin
      blink_cnt <= blink_cnt + 16'd1;
    end
  end

  assign blank = warn && !blink_lvl;
`endif

endmodule

// File: rtl/light_controller.sv
// Room light controller: manual/auto mode FSM with presence timeout.
// Optional pre-off warning blink enabled by macro LIGHT_CTRL_WARN_BLINK_EN.
module light_controller
  import light_pkg::*;
#(
  parameter int unsigned AUTO_SHUTDOWN_T = DEF_AUTO_SHUTDOWN_T,
  parameter int unsigned WARN_T          = DEF_WARN_T,
  parameter int unsigned BLINK_P         = DEF_BLINK_P
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic presence,
  input  logic dark,
  output logic led,
  output logic mode_auto
);

  if (AUTO_SHUTDOWN_T < 1 || AUTO_SHUTDOWN_T > 65535) begin : g_bad_shutdown
    $error("AUTO_SHUTDOWN_T out of range");
  end
  if (WARN_T >= AUTO_SHUTDOWN_T) begin : g_bad_warn
    $error("WARN_T must be below AUTO_SHUTDOWN_T");
  end
  if (BLINK_P < 1 || BLINK_P > 65535) begin : g_bad_blink
    $error("BLINK_P out of range");
  end

  light_state_t state, state_next;
  logic         expired;
  logic         timer_en;

  // NOTE: registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= MANUAL_OFF;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      MANUAL_OFF: if (a) state_next = AUTO_IDLE;
                  else if (b) state_next = MANUAL_ON;
      MANUAL_ON:  if (a) state_next = AUTO_IDLE;
                  else if (b) state_next = MANUAL_OFF;
      AUTO_IDLE:  if (a) state_next = MANUAL_OFF;
                  else if (presence && dark) state_next = AUTO_ON;
      AUTO_ON:    if (a) state_next = MANUAL_OFF;
                  else if (expired && !presence) state_next = AUTO_IDLE;
    endcase
  end

  assign timer_en = (state == AUTO_ON) && (state_next == AUTO_ON);

`ifdef LIGHT_CTRL_WARN_BLINK_EN
  logic blank;

  light_timer #(
    .AUTO_SHUTDOWN_T(AUTO_SHUTDOWN_T),
    .WARN_T         (WARN_T),
    .BLINK_P        (BLINK_P)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (timer_en),
    .clr    (presence),
    .expired(expired),
    .blank  (blank)
  );

  assign led = (state == MANUAL_ON) || ((state == AUTO_ON) && !blank);
`else
  light_timer #(
    .AUTO_SHUTDOWN_T(AUTO_SHUTDOWN_T)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (timer_en),
    .clr    (presence),
    .expired(expired)
  );

  assign led = (state == MANUAL_ON) || (state == AUTO_ON);
`endif

  assign mode_auto = (state == AUTO_IDLE) || (state == AUTO_ON);

endmodule

// File: tb/tb_light_controller.sv
// Self-checking bench for light_controller against a behavioural room model.
module tb_light_controller;

  localparam int T = 100;
  localparam int W = 20;
  localparam int P = 5;

  logic clk = 1'b0;
  logic rst = 1'b0, a = 1'b0, b = 1'b0, presence = 1'b0, dark = 1'b0;
  logic led, mode_auto;

  int compared   = 0;
  int mismatched = 0;

  // Reference: is the room in auto mode, is the lamp lit, how long idle.
  bit m_auto, m_lit;
  int m_idle;

  always #5 clk = ~clk;

  light_controller #(
    .AUTO_SHUTDOWN_T(T),
    .WARN_T         (W),
    .BLINK_P        (P)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .presence (presence),
    .dark     (dark),
    .led      (led),
    .mode_auto(mode_auto)
  );

  function automatic logic exp_led();
    if (!m_lit) return 1'b0;
    if (!m_auto) return 1'b1;
`ifdef LIGHT_CTRL_WARN_BLINK_EN
    if (m_idle >= T - W) return (((m_idle - (T - W)) / P) % 2) == 1;
`endif
    return 1'b1;
  endfunction

  task automatic step(input bit ir, input bit ia, input bit ib, input bit ip, input bit id);
    @(negedge clk);
    rst = ir; a = ia; b = ib; presence = ip; dark = id;
    @(posedge clk);
    if (ir) begin
      m_auto = 0; m_lit = 0; m_idle = 0;
    end else if (ia) begin
      m_auto = !m_auto; m_lit = 0; m_idle = 0;
    end else if (!m_auto) begin
      if (ib) m_lit = !m_lit;
    end else if (!m_lit) begin
      if (ip && id) begin m_lit = 1; m_idle = 0; end
    end else if (ip) begin
      m_idle = 0;
    end else if (m_idle == T - 1) begin
      m_lit = 0; m_idle = 0;
    end else begin
      m_idle++;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    step(1, 0, 1, 1, 1);
    compared++;
    if (led !== 1'b0) begin mismatched++; $display("FAIL reset_led: got %b want 0", led); end
    compared++;
    if (mode_auto !== 1'b0) begin mismatched++; $display("FAIL reset_mode: got %b want 0", mode_auto); end
  endtask

  task automatic test_manual();
    step(0, 0, 1, 0, 0);
    compared++;
    if (led !== 1'b1 || mode_auto !== 1'b0) begin
      mismatched++; $display("FAIL manual_on: led=%b mode=%b want 1/0", led, mode_auto);
    end
    step(0, 0, 0, 1, 1);
    compared++;
    if (led !== 1'b1) begin mismatched++; $display("FAIL manual_hold: led=%b want 1", led); end
    step(0, 0, 1, 0, 0);
    compared++;
    if (led !== 1'b0 || mode_auto !== 1'b0) begin
      mismatched++; $display("FAIL manual_off: led=%b mode=%b want 0/0", led, mode_auto);
    end
  endtask

  task automatic test_auto_timeout();
    int lit_cycles;
    int want_lit;
    step(0, 1, 0, 0, 0);
    compared++;
    if (led !== 1'b0 || mode_auto !== 1'b1) begin
      mismatched++; $display("FAIL auto_enter: led=%b mode=%b want 0/1", led, mode_auto);
    end
    step(0, 0, 0, 1, 1);
    compared++;
    if (led !== 1'b1) begin mismatched++; $display("FAIL auto_light: led=%b want 1", led); end
    lit_cycles = 1;
    for (int i = 0; i < T + 5; i++) begin
      step(0, 0, 0, 0, 1'($urandom));
      if (led === 1'b1) lit_cycles++;
      compared++;
      if (led !== exp_led() || mode_auto !== m_auto) begin
        mismatched++;
        $display("FAIL timeout_cycle%0d: led=%b mode=%b want %b/%b", i, led, mode_auto, exp_led(), m_auto);
      end
    end
`ifdef LIGHT_CTRL_WARN_BLINK_EN
    want_lit = (T - W) + (W / 2);
`else
    want_lit = T;
`endif
    compared++;
    if (lit_cycles != want_lit) begin
      mismatched++; $display("FAIL timeout_len: lit %0d cycles want %0d", lit_cycles, want_lit);
    end
    compared++;
    if (led !== 1'b0 || mode_auto !== 1'b1) begin
      mismatched++; $display("FAIL timeout_end: led=%b mode=%b want 0/1", led, mode_auto);
    end
  endtask

  task automatic test_presence_rules();
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 0);
      compared++;
      if (led !== 1'b0 || mode_auto !== 1'b1) begin
        mismatched++; $display("FAIL no_dark%0d: led=%b mode=%b want 0/1", i, led, mode_auto);
      end
    end
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < T - 1; i++) begin
      step(0, 0, 0, 0, 0);
      compared++;
      if (led !== exp_led()) begin
        mismatched++; $display("FAIL rescue_run%0d: led=%b want %b", i, led, exp_led());
      end
    end
    step(0, 0, 0, 1, 1'($urandom));
    compared++;
    if (led !== 1'b1 || mode_auto !== 1'b1) begin
      mismatched++; $display("FAIL rescue_hold: led=%b mode=%b want 1/1", led, mode_auto);
    end
    for (int i = 0; i < T - 1; i++) begin
      step(0, 0, 0, 0, 0);
      compared++;
      if (led !== exp_led()) begin
        mismatched++; $display("FAIL restart_run%0d: led=%b want %b", i, led, exp_led());
      end
    end
    step(0, 0, 0, 0, 0);
    compared++;
    if (led !== 1'b0 || mode_auto !== 1'b1) begin
      mismatched++; $display("FAIL restart_off: led=%b mode=%b want 0/1", led, mode_auto);
    end
  endtask

  task automatic test_priority();
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    compared++;
    if (led !== 1'b0 || mode_auto !== 1'b1) begin
      mismatched++; $display("FAIL a_over_b: led=%b mode=%b want 0/1", led, mode_auto);
    end
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 0);
      compared++;
      if (led !== 1'b1 || mode_auto !== 1'b1) begin
        mismatched++; $display("FAIL b_ignored%0d: led=%b mode=%b want 1/1", i, led, mode_auto);
      end
    end
  endtask

  task automatic test_reset_mid_countdown();
    for (int i = 0; i < 200 && m_idle != 50; i++) step(0, 0, 0, 0, 0);
    compared++;
    if (m_idle != 50 || led !== 1'b1) begin
      mismatched++; $display("FAIL countdown_50: led=%b idle=%0d want 1 at 50", led, m_idle);
    end
    step(1, 1, 1, 1, 1);
    compared++;
    if (led !== 1'b0 || mode_auto !== 1'b0) begin
      mismatched++; $display("FAIL reset_mid: led=%b mode=%b want 0/0", led, mode_auto);
    end
    step(0, 0, 0, 1, 1);
    compared++;
    if (led !== 1'b0 || mode_auto !== 1'b0) begin
      mismatched++; $display("FAIL manual_ignores_presence: led=%b mode=%b want 0/0", led, mode_auto);
    end
  endtask

  task automatic test_random();
    int rate;
    step(1, 0, 0, 0, 0);
    for (int seg = 0; seg < 8; seg++) begin
      rate = (seg % 2 == 0) ? 6 : 300;
      for (int i = 0; i < 500; i++) begin
        step($urandom_range(0, 999) == 0, $urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, rate - 1) == 0, 1'($urandom));
        compared++;
        if (led !== exp_led() || mode_auto !== m_auto) begin
          mismatched++;
          $display("FAIL random_s%0d_c%0d: led=%b mode=%b want %b/%b", seg, i, led, mode_auto, exp_led(), m_auto);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto_timeout();
    test_presence_rules();
    test_priority();
    test_reset_mid_countdown();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/light_controller.md
LIGHT_CONTROLLER -- requirements
Module: light_controller

Interface
REQ-001 SHALL have parameter AUTO_SHUTDOWN_T, default 30000, meaning cycles without presence before auto-mode light-off (1..65535).
REQ-002 SHALL have parameter WARN_T, default 5000, meaning length of the pre-off warning window in cycles (WARN_T < AUTO_SHUTDOWN_T).
REQ-003 SHALL have parameter BLINK_P, default 500, meaning warning blink half-period in cycles (1..65535).
REQ-004 SHALL have port clk  input  1  system clock, sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port a  input  1  long-press pulse from the push-button stage; toggles mode.
REQ-007 SHALL have port b  input  1  short-press pulse from the push-button stage; toggles light in manual mode.
REQ-008 SHALL have port presence  input  1  occupancy sensor, high = occupied, synchronous to clk.
REQ-009 SHALL have port dark  input  1  ambient light sensor, high = dark, synchronous to clk.
REQ-010 SHALL have port led  output  1  lamp drive, high = on.
REQ-011 SHALL have port mode_auto  output  1  high while in automatic mode.

Function
REQ-012 SHALL implement FSM states MANUAL_OFF, MANUAL_ON, AUTO_IDLE, AUTO_ON.
REQ-013 SHALL keep a 16-bit idle counter, cleared on every state change and on every cycle with presence=1 in AUTO_ON; otherwise it increments in AUTO_ON and holds 0 elsewhere.
REQ-014 SHALL, on a=1, move MANUAL_OFF/MANUAL_ON -> AUTO_IDLE and AUTO_IDLE/AUTO_ON -> MANUAL_OFF.
REQ-015 SHALL, on b=1 with a=0, toggle MANUAL_OFF <-> MANUAL_ON; b SHALL be ignored in both auto states.
REQ-016 SHALL give a priority over b when both are high in the same cycle.
REQ-017 SHALL move AUTO_IDLE -> AUTO_ON when presence=1 and dark=1 in the same cycle; presence without dark SHALL NOT light the lamp.
REQ-018 SHALL stay in AUTO_ON regardless of dark; it SHALL move AUTO_ON -> AUTO_IDLE when the counter equals AUTO_SHUTDOWN_T-1 and presence=0.
REQ-019 SHALL give presence=1 priority over the timeout in that same cycle: the counter clears and the state holds.
REQ-020 SHALL decode led and mode_auto from the registered state only, so they change one cycle after the sampled triggering input.
REQ-021 SHALL drive led=1 in MANUAL_ON and AUTO_ON, and 0 otherwise; mode_auto=1 in AUTO_IDLE and AUTO_ON.
REQ-022 SHALL never let the counter wrap; it SHALL saturate at AUTO_SHUTDOWN_T-1.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, enter MANUAL_OFF, clear counter and blink state, and drive led=0 and mode_auto=0 from the next cycle.
REQ-024 SHALL let reset override all inputs, including mid-countdown in AUTO_ON and a/b pulses in the same cycle.

Configuration
REQ-025 SHALL support macro LIGHT_CTRL_WARN_BLINK_EN.
REQ-026 SHALL, with LIGHT_CTRL_WARN_BLINK_EN defined, make led blink in AUTO_ON while counter >= AUTO_SHUTDOWN_T-WARN_T: led is 0 on the first warning cycle and toggles every BLINK_P cycles.
REQ-027 SHALL, with LIGHT_CTRL_WARN_BLINK_EN defined, restore steady led=1 on the cycle after presence clears the counter.
REQ-028 SHALL, without LIGHT_CTRL_WARN_BLINK_EN, hold led steady at 1 throughout AUTO_ON, with no blink logic synthesised.

Structure
REQ-029 SHALL take from shared package light_pkg: typedef light_state_t and default constants for AUTO_SHUTDOWN_T, WARN_T and BLINK_P.
REQ-030 SHALL place the idle counter and its saturation/compare logic in sub-module light_timer; the FSM and output decode stay in light_controller.

Verification
REQ-031 SHALL check: reset, then b pulse -> led=1 next cycle, mode_auto=0; second b pulse -> led=0.
REQ-032 SHALL check: AUTO_SHUTDOWN_T=100, a pulse, presence=1 and dark=1 for 1 cycle, then presence=0 -> led=1 for 100 cycles, then led=0, mode_auto=1.
REQ-033 SHALL check: auto mode, presence=1 with dark=0 -> led stays 0; presence pulse at counter=99 with AUTO_SHUTDOWN_T=100 -> no turn-off, counter restarts.
REQ-034 SHALL check: a=1 and b=1 in the same cycle from MANUAL_OFF -> AUTO_IDLE, led=0; b in AUTO_ON -> no effect.
REQ-035 SHALL check: rst asserted at counter=50 in AUTO_ON -> MANUAL_OFF, led=0, mode_auto=0 the next cycle.
REQ-036 SHALL check, with macro defined, AUTO_SHUTDOWN_T=100, WARN_T=20, BLINK_P=5: led drops at count 80 and toggles every 5 cycles until off at 100.
